decode_controller: RTL and testbench

Pipeline controller for the decode stage, sitting between the fetch controller (upstream) and the execute stage (downstream). It accepts instruction/PC pairs whenever `decode_enable` is high and holds them in a small skid buffer. It returns `fetch_stall_external` to the fetch controller, and issues to execute under downstream stall, load-use hazard and flush control.

---
 rtl/decode_controller.sv | 189 ++++++++++++++++++
 tb/tb_decode_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_controller.sv
// ---------------------------------------------------------------------------
// decode_controller
//
// Decode-stage pipeline controller. It buffers {instr, pc} pairs from the
// fetch controller in a small circular skid buffer. The head entry goes to
// execute, subject to downstream stall, a one-cycle load-use bubble and flush.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   decode_enable           fetch presents a valid instr_in/pc_in this cycle
//   instr_in, pc_in         fetched instruction and its PC
//   execute_stall_external  execute cannot accept this cycle
//   execute_is_load         instruction in execute is a load
//   execute_rd              destination register of the instruction in execute
//   flush                   redirect; drop everything buffered
//   fetch_stall_external    decode cannot accept (registered state only)
//   execute_enable          head entry is issued this cycle
//   decode_instr_out/pc_out head entry (0 when the buffer is empty)
//   rs1_addr/rs2_addr/rd_addr  register fields of the head entry
//   hazard_stall_count      saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module decode_controller #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,   // 2 or 4 only; the pointers rely on power-of-two wrap
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             decode_enable,
    input  logic [XLEN-1:0]  instr_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             execute_stall_external,
    input  logic             execute_is_load,
    input  logic [4:0]       execute_rd,
    input  logic             flush,
    output logic             fetch_stall_external,
    output logic             execute_enable,
    output logic [XLEN-1:0]  decode_instr_out,
    output logic [XLEN-1:0]  decode_pc_out,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic [CNT_W-1:0] hazard_stall_count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(BUF_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        HAZARD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   instr_mem [BUF_DEPTH];
    logic [XLEN-1:0]   pc_mem    [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [OCC_W-1:0]  count_q;
    logic              hazard_done_q;   // head already took its bubble
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              empty, full, push, pop;
    logic              uses_rs1, uses_rs2, hazard_raw, hazard_eff;
    logic [XLEN-1:0]   head_instr;
    logic [6:0]        opcode;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    assign head_instr       = empty ? '0 : instr_mem[head_q];
    assign decode_instr_out = head_instr;
    assign decode_pc_out    = empty ? '0 : pc_mem[head_q];
    assign rs1_addr         = head_instr[19:15];
    assign rs2_addr         = head_instr[24:20];
    assign rd_addr          = head_instr[11:7];
    assign opcode           = head_instr[6:0];

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL:  uses_rs1 = 1'b0;
            OP_R, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            default: ;
        endcase
    end

    assign hazard_raw = !empty && execute_is_load && (execute_rd != 5'd0) &&
                        ((uses_rs1 && (rs1_addr == execute_rd)) ||
                         (uses_rs2 && (rs2_addr == execute_rd)));

    // After the bubble the load result is forwardable, so the same head is
    // not re-checked; the flag clears once that head pops.
    assign hazard_eff = hazard_raw && !hazard_done_q;

    assign execute_enable = (state_q == DECODE) && !empty && !hazard_eff &&
                            !execute_stall_external && !flush;

    assign push = decode_enable && !flush && !full;
    assign pop  = execute_enable;

    // Registered terms only: fetch derives decode_enable from this signal.
    assign fetch_stall_external = full || (state_q == HAZARD);

    assign hazard_stall_count = stall_cnt_q;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) state_d = DECODE;
                end
                DECODE: begin
                    if (hazard_eff && !execute_stall_external)
                        state_d = HAZARD;
                    else if (pop && !push && (count_q == OCC_W'(1)))
                        state_d = IDLE;
                end
                HAZARD:  state_d = DECODE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            hazard_done_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == HAZARD) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush) begin
                head_q        <= '0;
                tail_q        <= '0;
                count_q       <= '0;
                hazard_done_q <= 1'b0;
            end else begin
                // Pointer width equals log2(depth), so increment wraps for free.
                if (push) tail_q <= tail_q + 1'b1;
                if (pop)  head_q <= head_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: ;
                endcase
                if (pop)
                    hazard_done_q <= 1'b0;
                else if (state_q == HAZARD)
                    hazard_done_q <= 1'b1;
            end
        end
    end

    // NOTE: buffer storage has no reset; an entry is only visible while
    // count covers it, and the outputs are forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= instr_in;
            pc_mem[tail_q]    <= pc_in;
        end
    end

    // Fetch must honour fetch_stall_external; a push into a full buffer is
    // dropped. During flush the incoming word is discarded anyway.
    assert property (@(posedge clk) disable iff (!reset_n)
                     !(decode_enable && !flush && full));

endmodule

// File: tb/tb_decode_controller.sv
// ---------------------------------------------------------------------------
// tb_decode_controller
//
// Directed bench for decode_controller (BUF_DEPTH = 2). Inputs change 1 ns
// after a rising edge; outputs are checked 1 ns later, well clear of edges.
// ---------------------------------------------------------------------------
module tb_decode_controller;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             decode_enable;
    logic [XLEN-1:0]  instr_in;
    logic [XLEN-1:0]  pc_in;
    logic             execute_stall_external;
    logic             execute_is_load;
    logic [4:0]       execute_rd;
    logic             flush;
    logic             fetch_stall_external;
    logic             execute_enable;
    logic [XLEN-1:0]  decode_instr_out;
    logic [XLEN-1:0]  decode_pc_out;
    logic [4:0]       rs1_addr, rs2_addr, rd_addr;
    logic [CNT_W-1:0] hazard_stall_count;

    int tests = 0;
    int fails = 0;

    decode_controller #(.XLEN(XLEN), .BUF_DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .decode_enable          (decode_enable),
        .instr_in               (instr_in),
        .pc_in                  (pc_in),
        .execute_stall_external (execute_stall_external),
        .execute_is_load        (execute_is_load),
        .execute_rd             (execute_rd),
        .flush                  (flush),
        .fetch_stall_external   (fetch_stall_external),
        .execute_enable         (execute_enable),
        .decode_instr_out       (decode_instr_out),
        .decode_pc_out          (decode_pc_out),
        .rs1_addr               (rs1_addr),
        .rs2_addr               (rs2_addr),
        .rd_addr                (rd_addr),
        .hazard_stall_count     (hazard_stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [31:0] instr, input logic [31:0] pc);
        decode_enable = en;
        instr_in      = instr;
        pc_in         = pc;
    endtask

    initial begin
        reset_n                = 1'b0;
        decode_enable          = 1'b0;
        instr_in               = '0;
        pc_in                  = '0;
        execute_stall_external = 1'b0;
        execute_is_load        = 1'b0;
        execute_rd             = '0;
        flush                  = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_exec_en",  execute_enable, 0);
        check("rst_fstall",   fetch_stall_external, 0);
        check("rst_instr",    decode_instr_out, 0);
        check("rst_pc",       decode_pc_out, 0);
        check("rst_hcnt",     hazard_stall_count, 0);
        #10 reset_n = 1'b1;
        tick();

        // ---------------- 1. streaming ----------------
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, NOP, 32'(4 * i));
            #1;
            check("str_exec_en", execute_enable, (i > 0) ? 1 : 0);
            if (i > 0) check("str_pc", decode_pc_out, 32'(4 * (i - 1)));
            check("str_fstall", fetch_stall_external, 0);
            check("str_cnt_le1", (dut.count_q <= 1) ? 1 : 0, 1);
            tick();
        end
        drive(1'b0, '0, '0);
        #1;
        check("str_last_en", execute_enable, 1);
        check("str_last_pc", decode_pc_out, 32'h14);
        tick();
        check("str_drain_en",    execute_enable, 0);
        check("str_drain_instr", decode_instr_out, 0);

        // ---------------- 2. back-pressure ----------------
        execute_stall_external = 1'b1;
        drive(1'b1, NOP, 32'h100);
        #1;
        check("bp_c0_en", execute_enable, 0);
        tick();
        drive(1'b1, NOP, 32'h104);
        #1;
        check("bp_c1_fstall", fetch_stall_external, 0);
        check("bp_c1_en",     execute_enable, 0);
        tick();
        drive(1'b0, '0, '0);
        #1;
        check("bp_c2_fstall", fetch_stall_external, 1);
        check("bp_c2_count",  dut.count_q, 2);
        tick();
        check("bp_c3_fstall", fetch_stall_external, 1);
        check("bp_c3_pc",     decode_pc_out, 32'h100);
        tick();
        execute_stall_external = 1'b0;
        #1;
        check("bp_c4_en",     execute_enable, 1);
        check("bp_c4_pc",     decode_pc_out, 32'h100);
        check("bp_c4_fstall", fetch_stall_external, 1);
        tick();
        drive(1'b1, NOP, 32'h108);
        #1;
        check("bp_c5_fstall", fetch_stall_external, 0);
        check("bp_c5_en",     execute_enable, 1);
        check("bp_c5_pc",     decode_pc_out, 32'h104);
        tick();
        drive(1'b0, '0, '0);
        #1;
        check("bp_c6_en", execute_enable, 1);
        check("bp_c6_pc", decode_pc_out, 32'h108);
        tick();
        check("bp_c7_en", execute_enable, 0);

        // ---------------- 3. load-use ----------------
        execute_is_load = 1'b1;
        execute_rd      = 5'd5;
        drive(1'b1, 32'h0052_8333, 32'h200);
        #1;
        check("lu_h0_en", execute_enable, 0);
        tick();
        drive(1'b0, '0, '0);
        #1;
        check("lu_rs1",       rs1_addr, 5);
        check("lu_rs2",       rs2_addr, 5);
        check("lu_rd",        rd_addr, 6);
        check("lu_h1_en",     execute_enable, 0);
        check("lu_h1_fstall", fetch_stall_external, 0);
        tick();
        check("lu_hz_en",     execute_enable, 0);
        check("lu_hz_fstall", fetch_stall_external, 1);
        check("lu_hz_cnt",    hazard_stall_count, 0);
        tick();
        check("lu_issue_en",  execute_enable, 1);
        check("lu_issue_pc",  decode_pc_out, 32'h200);
        check("lu_cnt",       hazard_stall_count, 1);
        check("lu_fstall",    fetch_stall_external, 0);
        tick();
        check("lu_after_en",  execute_enable, 0);

        // ---------------- 4. no false hazard ----------------
        drive(1'b1, 32'h0000_52B7, 32'h300);
        #1;
        tick();
        drive(1'b1, 32'h0000_0333, 32'h304);
        #1;
        check("nf_lui_en", execute_enable, 1);
        check("nf_lui_pc", decode_pc_out, 32'h300);
        tick();
        drive(1'b0, '0, '0);
        execute_rd = 5'd0;
        #1;
        check("nf_x0_en",  execute_enable, 1);
        check("nf_x0_pc",  decode_pc_out, 32'h304);
        tick();
        check("nf_cnt",    hazard_stall_count, 1);
        check("nf_idle_en", execute_enable, 0);
        execute_is_load = 1'b0;

        // ---------------- 5. flush with full buffer ----------------
        execute_stall_external = 1'b1;
        drive(1'b1, NOP, 32'h400);
        #1;
        tick();
        drive(1'b1, NOP, 32'h404);
        #1;
        tick();
        execute_stall_external = 1'b0;
        flush = 1'b1;
        drive(1'b1, NOP, 32'h408);
        #1;
        check("fl_full",     fetch_stall_external, 1);
        check("fl_exec_en",  execute_enable, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        #1;
        check("fl_count",  dut.count_q, 0);
        check("fl_instr",  decode_instr_out, 0);
        check("fl_pc",     decode_pc_out, 0);
        check("fl_en",     execute_enable, 0);
        check("fl_fstall", fetch_stall_external, 0);
        check("fl_hcnt",   hazard_stall_count, 1);
        tick();
        check("fl_still_en", execute_enable, 0);

        // ---------------- 6. async reset mid-stream ----------------
        drive(1'b1, NOP, 32'h500);
        #1;
        tick();
        drive(1'b1, NOP, 32'h504);
        #1;
        check("rs_pre_en", execute_enable, 1);
        tick();
        drive(1'b1, NOP, 32'h508);
        #2;
        reset_n = 1'b0;
        #1;
        check("rs_en",     execute_enable, 0);
        check("rs_instr",  decode_instr_out, 0);
        check("rs_pc",     decode_pc_out, 0);
        check("rs_fstall", fetch_stall_external, 0);
        check("rs_hcnt",   hazard_stall_count, 0);
        drive(1'b0, '0, '0);
        #2;
        reset_n = 1'b1;
        tick();
        drive(1'b1, NOP, 32'h600);
        #1;
        check("rs_p0_en", execute_enable, 0);
        tick();
        drive(1'b0, '0, '0);
        #1;
        check("rs_p1_en", execute_enable, 1);
        check("rs_p1_pc", decode_pc_out, 32'h600);
        tick();
        check("rs_p2_en", execute_enable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
